// File: rtl/seq_signed_div.sv
// Sequential signed restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per clock.
// Operands are reduced to magnitudes on accept; signs are reapplied in a single FIX cycle.
module seq_signed_div #(
  parameter int WN = 32,
  parameter int WD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [WN-1:0] quotient,
  output logic [WD-1:0] remainder,
  output logic          dz
);

  localparam int CW = $clog2(WN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WD-1:0] r_p;
  logic [WN-1:0] r_a;
  logic [WD-1:0] r_dvs;
  logic [WD-1:0] r_dvd_lo;
  logic          r_sq;
  logic          r_sr;
  logic          r_dzp;

  logic [WN-1:0] w_mag_dvd;
  logic [WD-1:0] w_mag_dvs;
  logic [WD:0]   w_shift_p;
  logic [WD-1:0] w_diff;
  logic          w_ge;

  // -2^(N-1) negates to itself, which reads correctly as an unsigned magnitude
  assign w_mag_dvd = dividend[WN-1] ? -dividend : dividend;
  assign w_mag_dvs = divisor[WD-1]  ? -divisor  : divisor;

  // Partial remainder stays below |divisor|, so the difference always fits WD bits
  assign w_shift_p = {r_p, r_a[WN-1]};
  assign w_ge      = (w_shift_p >= {1'b0, r_dvs});
  assign w_diff    = w_shift_p[WD-1:0] - r_dvs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_p       <= '0;
      r_a       <= '0;
      r_dvs     <= '0;
      r_dvd_lo  <= '0;
      r_sq      <= 1'b0;
      r_sr      <= 1'b0;
      r_dzp     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= w_mag_dvd;
            r_dvs    <= w_mag_dvs;
            r_dvd_lo <= dividend[WD-1:0];
            r_sq     <= dividend[WN-1] ^ divisor[WD-1];
            r_sr     <= dividend[WN-1];
            r_p      <= '0;
            busy     <= 1'b1;
            if (divisor == '0) begin
              r_dzp   <= 1'b1;
              r_state <= FIX;
            end else begin
              r_dzp   <= 1'b0;
              r_cnt   <= CW'(WN);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_p   <= w_ge ? w_diff : w_shift_p[WD-1:0];
          r_a   <= {r_a[WN-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          if (r_dzp) begin
            quotient  <= '1;
            remainder <= r_dvd_lo;
          end else begin
            quotient  <= r_sq ? -r_a : r_a;
            remainder <= r_sr ? -r_p : r_p;
          end
          dz      <= r_dzp;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_div.sv
// Directed bench for seq_signed_div: hand-computed quotients/remainders, latency, dz, abort and busy-ignore.
module tb_seq_signed_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, dz;
  logic [31:0] quotient;
  logic [15:0] remainder;

  int checks   = 0;
  int failures = 0;

  seq_signed_div #(.WN(32), .WD(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request; inputs are changed #1 after a posedge, outputs sampled #1 after a posedge
  task automatic run_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                         input int exp_lat, input logic [31:0] eq, input logic [15:0] er,
                         input logic edz);
    int n;
    dividend = dvd; divisor = dvs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~dvd; divisor = ~dvs;
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (done) break;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, dz, edz);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", dz, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_div("t1",      32'd100,       16'd7,    33, 32'd14,        16'd2,      0);
    run_div("t2a",     -32'sd100,     16'd7,    33, 32'hFFFFFFF2,  16'hFFFE,   0);
    run_div("t2b",     32'd100,       -16'sd7,  33, -32'sd14,      16'd2,      0);
    run_div("t3a",     32'd80000,     16'd400,  33, 32'd200,       16'd0,      0);
    run_div("t3b",     32'd80001,     -16'sd400,33, -32'sd200,     16'd1,      0);
    run_div("t4dz",    32'h1234ABCD,  16'd0,    1,  32'hFFFFFFFF,  16'hABCD,   1);
    run_div("t4clr",   32'd50,        16'd5,    33, 32'd10,        16'd0,      0);
    run_div("t5a",     32'h80000000,  16'hFFFF, 33, 32'h80000000,  16'd0,      0);
    run_div("t5b",     32'h80000000,  16'h8000, 33, 32'd65536,     16'd0,      0);
    run_div("t5c",     -32'sd7,       -16'sd2,  33, 32'd3,         16'hFFFF,   0);

    // Results hold through idle cycles
    repeat (4) @(posedge clk); #1;
    chk("hold_q", quotient, 32'd3);
    chk("hold_done", done, 0);

    // Start re-pulsed while busy must be ignored
    begin
      int n;
      dividend = 32'd1000; divisor = 16'd10; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) @(posedge clk); #1;
      dividend = 32'd999; divisor = 16'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 6;
      while (n < 100) begin
        @(posedge clk); #1; n++;
        if (done) break;
      end
      chk("t6busy_lat", n, 33);
      chk("t6busy_q", quotient, 32'd100);
      chk("t6busy_r", remainder, 16'd0);
      @(posedge clk); #1;
      chk("t6busy_nodone", done, 0);
    end

    // Reset during CALC aborts with no done pulse
    begin
      int seen;
      dividend = 32'd12345; divisor = 16'd11; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk); #1;
      rst = 1'b1; #1;
      chk("t6rst_busy", busy, 0);
      chk("t6rst_q", quotient, 0);
      chk("t6rst_r", remainder, 0);
      chk("t6rst_dz", dz, 0);
      @(negedge clk); rst = 1'b0;
      seen = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      chk("t6rst_quiet", seen, 0);
    end
    run_div("t6after", 32'd12345, 16'd11, 33, 32'd1122, 16'd3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
